// File: rtl/crc_enc_arbiter.sv
// crc_enc_arbiter
//   Round-robin scheduler sharing one serial (7,3) CRC encoder between N_REQ
//   requesters. A granted requester's 3-bit word is latched, shifted MSB first
//   into the encoder, and the 7-bit serial codeword is collected and presented
//   with the owning requester's ID.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req, i_data     per-requester level request and 3-bit data word
//   o_gnt             one-hot grant pulse (word captured on that edge)
//   o_busy            frame in progress
//   o_enc_rst_n       registered active-low encoder reset (frames each codeword)
//   o_enc_data        registered serial data bit to the encoder
//   i_enc_code        serial code bit from the encoder
//   i_enc_done        encoder done flag, expected only with the last code bit
//   o_code, o_code_id codeword (bit 6 first on the wire) and its owner
//   o_code_valid      one-cycle pulse when o_code / o_code_id update
//   o_err             one-cycle pulse on an encoder done-flag violation
module crc_enc_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [3*N_REQ-1:0] i_data,
    output logic [N_REQ-1:0]   o_gnt,
    output logic               o_busy,
    output logic               o_enc_rst_n,
    output logic               o_enc_data,
    input  logic               i_enc_code,
    input  logic               i_enc_done,
    output logic [6:0]         o_code,
    output logic [ID_W-1:0]    o_code_id,
    output logic               o_code_valid,
    output logic               o_err
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      k;          // step counter; value k is the step before edge E(k+1)
    logic [2:0]      w;          // latched data word
    logic [ID_W-1:0] id;         // owner of the frame in flight
    logic [ID_W-1:0] last;       // most recent winner
    logic [5:0]      sreg;       // first six code bits; the seventh joins at E8

    logic [2:0]      words [N_REQ];
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] sel_idx;
    logic            sel_found;
    logic            in_check;
    logic            last_step;
    logic            done_bad;

    for (genvar g = 0; g < N_REQ; g++) begin : g_word
        assign words[g] = i_data[3*g +: 3];
    end

    // Search downward so the lowest offset from last+1 is the final assignment,
    // i.e. the first requester at or after last+1 wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = ID_W'((int'(last) + i) % N_REQ);
            if (i_req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Done must stay low for the code bits sampled at E2..E7 and be high at E8.
    always_comb begin
        o_busy    = (state != IDLE);
        in_check  = (state == RUN) && (k != 3'd0);
        last_step = (k == 3'd7);
        done_bad  = in_check && (i_enc_done != last_step);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (sel_found) state_next = RUN;
            RUN:  if (done_bad || last_step) state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            k            <= '0;
            w            <= '0;
            id           <= '0;
            last         <= ID_W'(N_REQ - 1);
            sreg         <= '0;
            o_gnt        <= '0;
            o_enc_rst_n  <= 1'b0;
            o_enc_data   <= 1'b0;
            o_code       <= '0;
            o_code_id    <= '0;
            o_code_valid <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_gnt        <= '0;
            o_code_valid <= 1'b0;
            o_err        <= 1'b0;
            case (state)
                IDLE: begin
                    o_enc_rst_n <= 1'b0;
                    o_enc_data  <= 1'b0;
                    if (sel_found) begin
                        w           <= words[sel_idx];
                        o_gnt       <= N_REQ'(1) << sel_idx;
                        id          <= sel_idx;
                        last        <= sel_idx;
                        k           <= '0;
                        o_enc_rst_n <= 1'b1;
                        o_enc_data  <= words[sel_idx][2];
                    end
                end
                RUN: begin
                    k <= k + 3'd1;
                    case (k)
                        3'd0:    o_enc_data <= w[1];
                        3'd1:    o_enc_data <= w[0];
                        default: o_enc_data <= 1'b0;
                    endcase
                    if (in_check) sreg <= {sreg[4:0], i_enc_code};
                    if (done_bad) begin
                        // Abort: codeword outputs keep their previous values.
                        o_err       <= 1'b1;
                        o_enc_rst_n <= 1'b0;
                        o_enc_data  <= 1'b0;
                    end else if (last_step) begin
                        o_code       <= {sreg, i_enc_code};
                        o_code_id    <= id;
                        o_code_valid <= 1'b1;
                        o_enc_rst_n  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_enc_arbiter.sv
// Self-checking bench for crc_enc_arbiter with a behavioural serial encoder
// stub and a round-robin / polynomial-division reference model.
module tb_crc_enc_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req;
    logic [3*N-1:0] i_data;
    logic [N-1:0]   o_gnt;
    logic           o_busy;
    logic           o_enc_rst_n;
    logic           o_enc_data;
    logic           i_enc_code;
    logic           i_enc_done;
    logic [6:0]     o_code;
    logic [IDW-1:0] o_code_id;
    logic           o_code_valid;
    logic           o_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int err_mode = 0;   // 0 normal, 1 done raised early (seen at E5), 2 done never raised
    int rr_last  = N - 1;

    crc_enc_arbiter #(.N_REQ(N), .ID_W(IDW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_data      (i_data),
        .o_gnt       (o_gnt),
        .o_busy      (o_busy),
        .o_enc_rst_n (o_enc_rst_n),
        .o_enc_data  (o_enc_data),
        .i_enc_code  (i_enc_code),
        .i_enc_done  (i_enc_done),
        .o_code      (o_code),
        .o_code_id   (o_code_id),
        .o_code_valid(o_code_valid),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Systematic (7,3) code: data bits then remainder of d(x)*x^4 mod x^4+x^2+x+1.
    function automatic logic [6:0] crc73(input logic [2:0] d);
        logic [6:0] r;
        r = {d, 4'b0000};
        for (int b = 6; b >= 4; b--)
            if (r[b]) r = r ^ (7'b0010111 << (b - 4));
        return {d, r[3:0]};
    endfunction

    function automatic int exp_grant(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (last + i) % N;
            if (((req >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    function automatic logic [2:0] word_of(input logic [3*N-1:0] d, input int idx);
        return 3'((d >> (3 * idx)) & 7);
    endfunction

    // Encoder stub: echoes the 3 data bits, then emits the 4 check bits.
    logic [2:0] st_cnt;
    logic [2:0] st_d;
    logic [6:0] st_cw;
    assign st_cw = crc73(st_d);

    always @(posedge i_clk) begin
        if (!o_enc_rst_n) begin
            st_cnt     <= 3'd0;
            st_d       <= 3'd0;
            i_enc_code <= 1'b0;
            i_enc_done <= 1'b0;
        end else begin
            st_cnt     <= st_cnt + 3'd1;
            st_d       <= (st_cnt < 3'd3) ? {st_d[1:0], o_enc_data} : st_d;
            i_enc_code <= (st_cnt < 3'd3) ? o_enc_data : st_cw[3'd6 - st_cnt];
            i_enc_done <= (err_mode == 2) ? 1'b0 :
                          (err_mode == 1) ? (st_cnt == 3'd3) : (st_cnt == 3'd6);
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    // Drives one request, then observes the 8 cycles after the grant edge.
    task automatic run_frame(input logic [N-1:0] req, input logic [3*N-1:0] data, input bit hold,
                             output logic [N-1:0] gnt, output int gnt_cyc, output int lat,
                             output logic [6:0] code, output logic [IDW-1:0] id,
                             output int n_valid, output int n_err, output int err_at,
                             output logic [1:0] aft_err, output int busy_bad, output int extra_gnt);
        i_req  = req;
        i_data = data;
        tick;
        gnt     = o_gnt;
        gnt_cyc = cyc;
        if (!hold) i_req = '0;
        lat = 0; n_valid = 0; n_err = 0; err_at = 0; aft_err = 2'b11;
        busy_bad = 0; extra_gnt = 0; code = o_code; id = o_code_id;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (o_gnt != '0) extra_gnt++;
            if (o_code_valid) begin
                n_valid++;
                if (lat == 0) begin lat = c; code = o_code; id = o_code_id; end
            end
            if (o_err) begin
                n_err++;
                if (err_at == 0) begin err_at = c; aft_err = {o_enc_rst_n, o_busy}; end
            end
            if (n_err == 0 && o_busy !== (c < 8)) busy_bad++;
        end
        if (n_err != 0) code = o_code;
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_req = '0; i_data = '0;
        tick; tick;
        checks++;
        if ({o_gnt, o_busy, o_enc_rst_n, o_enc_data, o_code, o_code_id, o_code_valid, o_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {o_gnt, o_busy, o_enc_rst_n, o_enc_data, o_code, o_code_id, o_code_valid, o_err});
        end
        i_rst = 1'b0;
        rr_last = N - 1;
        tick; tick; tick;
        checks++;
        if (o_gnt !== '0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: gnt=%b busy=%b required 0/0", o_gnt, o_busy);
        end
    endtask

    task automatic test_single;
        logic [N-1:0] g; logic [6:0] cd; logic [IDW-1:0] id; logic [1:0] ae;
        int gc, lat, nv, ne, ea, bb, xg;
        run_frame(4'b0001, 12'b000_000_000_100, 1'b0, g, gc, lat, cd, id, nv, ne, ea, ae, bb, xg);
        rr_last = 0;
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b required 0001", g); end
        checks++; if (lat != 8) begin errors++; $display("FAIL single_latency: got %0d required 8", lat); end
        checks++; if (cd !== 7'b1001011) begin errors++; $display("FAIL single_code: got %b required 1001011", cd); end
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d required 0", id); end
        checks++; if (nv != 1 || ne != 0) begin errors++; $display("FAIL single_pulses: valid=%0d err=%0d required 1/0", nv, ne); end
        checks++; if (bb != 0 || xg != 0) begin errors++; $display("FAIL single_busy_gnt: busy_bad=%0d extra_gnt=%0d required 0/0", bb, xg); end
        tick;
        checks++;
        if (o_code_valid !== 1'b0 || o_code !== 7'b1001011) begin
            errors++;
            $display("FAIL single_hold: valid=%b code=%b required 0/1001011", o_code_valid, o_code);
        end
    endtask

    task automatic test_code_values;
        logic [2:0] wv [2];
        logic [6:0] ev [2];
        logic [N-1:0] g; logic [6:0] cd; logic [IDW-1:0] id; logic [1:0] ae;
        int gc, lat, nv, ne, ea, bb, xg, e;
        wv[0] = 3'b111; ev[0] = 7'b1110010;
        wv[1] = 3'b000; ev[1] = 7'b0000000;
        for (int t = 0; t < 2; t++) begin
            e = exp_grant(4'b0100, rr_last);
            run_frame(4'b0100, {3'b000, wv[t], 6'b000000}, 1'b0, g, gc, lat, cd, id, nv, ne, ea, ae, bb, xg);
            rr_last = e;
            checks++;
            if (cd !== ev[t] || id !== 2'd2 || g !== 4'b0100 || nv != 1) begin
                errors++;
                $display("FAIL code_value_%0d: code=%b id=%0d gnt=%b valid=%0d required %b/2/0100/1",
                         t, cd, id, g, nv, ev[t]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] g; logic [6:0] cd; logic [IDW-1:0] id; logic [1:0] ae;
        logic [3*N-1:0] d;
        int gc, lat, nv, ne, ea, bb, xg, e, prev_gc;
        int order [5];
        order = '{0, 1, 2, 3, 0};
        i_rst = 1'b1; tick; i_rst = 1'b0; rr_last = N - 1;
        d = 12'($urandom);
        prev_gc = 0;
        for (int f = 0; f < 5; f++) begin
            e = exp_grant(4'b1111, rr_last);
            run_frame(4'b1111, d, 1'b1, g, gc, lat, cd, id, nv, ne, ea, ae, bb, xg);
            rr_last = e;
            checks++;
            if (g !== (4'b0001 << order[f]) || e != order[f]) begin
                errors++;
                $display("FAIL rr_order_%0d: gnt=%b model=%0d required requester %0d", f, g, e, order[f]);
            end
            checks++;
            if (id !== IDW'(order[f]) || cd !== crc73(word_of(d, order[f])) || lat != 8) begin
                errors++;
                $display("FAIL rr_code_%0d: id=%0d code=%b lat=%0d required %0d/%b/8",
                         f, id, cd, lat, order[f], crc73(word_of(d, order[f])));
            end
            if (f > 0) begin
                checks++;
                if (gc - prev_gc != 9 || xg != 0) begin
                    errors++;
                    $display("FAIL rr_period_%0d: spacing=%0d extra_gnt=%0d required 9/0", f, gc - prev_gc, xg);
                end
            end
            prev_gc = gc;
        end
        i_req = '0;
        tick;
    endtask

    task automatic test_skip_wrap;
        logic [N-1:0] g; logic [6:0] cd; logic [IDW-1:0] id; logic [1:0] ae;
        logic [3*N-1:0] d;
        int gc, lat, nv, ne, ea, bb, xg;
        d = 12'($urandom);
        run_frame(4'b0010, d, 1'b0, g, gc, lat, cd, id, nv, ne, ea, ae, bb, xg);
        rr_last = 1;
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL skip_setup: got %b required 0010", g); end
        run_frame(4'b1001, d, 1'b1, g, gc, lat, cd, id, nv, ne, ea, ae, bb, xg);
        checks++;
        if (g !== 4'b1000 || cd !== crc73(word_of(d, 3))) begin
            errors++; $display("FAIL skip_first: gnt=%b code=%b required 1000/%b", g, cd, crc73(word_of(d, 3)));
        end
        run_frame(4'b1001, d, 1'b1, g, gc, lat, cd, id, nv, ne, ea, ae, bb, xg);
        i_req = '0;
        rr_last = 0;
        checks++;
        if (g !== 4'b0001 || id !== 2'd0) begin
            errors++; $display("FAIL skip_wrap: gnt=%b id=%0d required 0001/0", g, id);
        end
        tick;
    endtask

    task automatic test_protocol_error;
        logic [N-1:0] g; logic [6:0] cd; logic [IDW-1:0] id; logic [1:0] ae;
        logic [6:0] prev;
        logic [3*N-1:0] d;
        int gc, lat, nv, ne, ea, bb, xg, e;
        int want_at [2];
        want_at = '{5, 8};
        for (int m = 1; m <= 2; m++) begin
            prev = o_code;
            d = 12'($urandom);
            err_mode = m;
            e = exp_grant(4'b0110, rr_last);
            run_frame(4'b0110, d, 1'b0, g, gc, lat, cd, id, nv, ne, ea, ae, bb, xg);
            rr_last = e;
            checks++;
            if (ea != want_at[m-1] || ne != 1) begin
                errors++; $display("FAIL err_edge_m%0d: err at E%0d count=%0d required E%0d/1", m, ea, ne, want_at[m-1]);
            end
            checks++;
            if (nv != 0 || cd !== prev) begin
                errors++; $display("FAIL err_no_valid_m%0d: valid=%0d code=%b required 0/%b", m, nv, cd, prev);
            end
            checks++;
            if (ae !== 2'b00) begin
                errors++; $display("FAIL err_abort_m%0d: {enc_rst_n,busy}=%b required 00", m, ae);
            end
        end
        err_mode = 0;
        d = 12'($urandom);
        e = exp_grant(4'b0100, rr_last);
        run_frame(4'b0100, d, 1'b0, g, gc, lat, cd, id, nv, ne, ea, ae, bb, xg);
        rr_last = e;
        checks++;
        if (cd !== crc73(word_of(d, 2)) || nv != 1 || ne != 0) begin
            errors++; $display("FAIL err_recover: code=%b valid=%0d err=%0d required %b/1/0", cd, nv, ne, crc73(word_of(d, 2)));
        end
    endtask

    task automatic test_mid_frame_reset;
        logic [N-1:0] g; logic [6:0] cd; logic [IDW-1:0] id; logic [1:0] ae;
        logic [3*N-1:0] d;
        int gc, lat, nv, ne, ea, bb, xg, pulses;
        i_req = 4'b0100; i_data = 12'($urandom);
        tick;
        i_req = '0;
        tick; tick; tick;
        i_rst = 1'b1;
        tick;
        checks++;
        if ({o_gnt, o_busy, o_enc_rst_n, o_enc_data, o_code, o_code_id, o_code_valid, o_err} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b required all zero",
                     {o_gnt, o_busy, o_enc_rst_n, o_enc_data, o_code, o_code_id, o_code_valid, o_err});
        end
        i_rst = 1'b0;
        rr_last = N - 1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (o_code_valid || o_err) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL midreset_pulses: got %0d required 0", pulses); end
        d = 12'($urandom);
        run_frame(4'b1111, d, 1'b0, g, gc, lat, cd, id, nv, ne, ea, ae, bb, xg);
        rr_last = 0;
        checks++;
        if (g !== 4'b0001 || cd !== crc73(word_of(d, 0))) begin
            errors++; $display("FAIL midreset_regrant: gnt=%b code=%b required 0001/%b", g, cd, crc73(word_of(d, 0)));
        end
    endtask

    task automatic test_random;
        logic [N-1:0] g; logic [6:0] cd; logic [IDW-1:0] id; logic [1:0] ae;
        logic [N-1:0] req;
        logic [3*N-1:0] d;
        int gc, lat, nv, ne, ea, bb, xg, e, gap;
        for (int f = 0; f < 20; f++) begin
            req = N'($urandom_range(1, (1 << N) - 1));
            d   = 12'($urandom);
            e   = exp_grant(req, rr_last);
            run_frame(req, d, 1'b0, g, gc, lat, cd, id, nv, ne, ea, ae, bb, xg);
            rr_last = e;
            checks++;
            if (g !== (4'b0001 << e) || id !== IDW'(e) || cd !== crc73(word_of(d, e)) ||
                lat != 8 || nv != 1 || ne != 0 || bb != 0) begin
                errors++;
                $display("FAIL random_%0d: req=%b gnt=%b id=%0d code=%b lat=%0d v=%0d e=%0d bb=%0d required gnt=%b id=%0d code=%b",
                         f, req, g, id, cd, lat, nv, ne, bb, 4'b0001 << e, e, crc73(word_of(d, e)));
            end
            gap = $urandom_range(0, 2);
            for (int c = 0; c < gap; c++) tick;
        end
    endtask

    initial begin
        i_rst = 1'b1; i_req = '0; i_data = '0;
        test_reset;
        test_single;
        test_code_values;
        test_back_to_back;
        test_skip_wrap;
        test_protocol_error;
        test_mid_frame_reset;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_enc_arbiter.md
# crc_enc_arbiter

Round-robin scheduler that shares one serial (7,3) CRC encoder between `N_REQ` requesters. It latches a granted requester's 3-bit data word and serialises it into the encoder. It controls the encoder's reset to frame each codeword, deserialises the 7-bit codeword and presents it with the requester ID. It sits between parallel data producers and the team's serial CRC encoder. That encoder takes 3 data bits in, sends 7 code bits out (data bits first, then 4 check bits), and raises its done flag with the last bit.

## Interface
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default 2: width of the requester ID; 2^`ID_W` must be at least `N_REQ`.
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `i_req`  in  `N_REQ`  level request, one bit per requester.
- `i_data`  in  3*`N_REQ`  data words; requester k uses bits [3k+2:3k].
- `o_gnt`  out  `N_REQ`  one-hot, one-cycle grant pulse; the word was captured on this edge.
- `o_busy`  out  1  high whenever the state is not IDLE.
- `o_enc_rst_n`  out  1  active-low reset to the encoder, registered.
- `o_enc_data`  out  1  serial data to the encoder, registered.
- `i_enc_code`  in  1  serial code bit from the encoder.
- `i_enc_done`  in  1  done flag from the encoder.
- `o_code`  out  7  codeword; bit 6 is the first serial bit.
- `o_code_id`  out  `ID_W`  index of the requester that owns `o_code`.
- `o_code_valid`  out  1  one-cycle pulse when `o_code` and `o_code_id` update.
- `o_err`  out  1  one-cycle pulse on an encoder protocol violation.

## Operation
- **States:** IDLE and RUN. RUN uses a 3-bit step counter `k`.
- **IDLE:**
  - `o_enc_rst_n`=0 and `o_enc_data`=0.
  - If any `i_req` bit is high, grant the first requester at or after `last+1`, wrapping modulo `N_REQ`.
  - On the grant edge: latch the word into `w`, set `o_gnt` for that requester, record its ID, set `last` to the winner, set `k`=0, set `o_enc_rst_n`=1, set `o_enc_data`=`w[2]`, go to RUN.
- **Round-robin pointer:** after reset `last`=`N_REQ`-1, so requester 0 wins first. Requesters that are not requesting are skipped with no idle cycles.
- **Requester handshake:** a requester drives `i_data` stable while `i_req` is high and drops `i_req` after seeing `o_gnt`. If `i_req` is still high at the next IDLE, that is a new request.
- **RUN:** call the grant edge E0. On edges E1..E8, `k` increments.
- **Data serialisation:** `o_enc_data` is set to `w[1]` at E1, `w[0]` at E2, and 0 at E3..E8.
- **Code capture:** at E2..E8, shift `i_enc_code` into the codeword shift register, MSB first.
- **Done check:**
  - At E2..E7, `i_enc_done` must be 0.
  - At E8, `i_enc_done` must be 1.
  - Any mismatch: pulse `o_err`, suppress `o_code_valid`, keep `o_code` unchanged, drive `o_enc_rst_n`=0, go to IDLE immediately.
- **Normal end at E8:** load `o_code` from the shift register, load `o_code_id` from the recorded ID, pulse `o_code_valid`, drive `o_enc_rst_n`=0, go to IDLE.
- **Input handling:** `i_req` is ignored during RUN. `i_data` is read only on the grant edge.

## Timing
- **Reset values:** on `i_rst`=1 at an edge, set all outputs to 0 (including `o_enc_rst_n`=0), state=IDLE, `k`=0, `last`=`N_REQ`-1.
- **Reset mid-frame:** reset mid-RUN aborts the frame with no `o_code_valid` and no `o_err`.
- **Latency:** from the grant edge E0 to the `o_code_valid` edge is 8 cycles.
- **Throughput:** the earliest next grant is E9, so the minimum frame period is 9 cycles.
- **`o_gnt`:** high only during cycle E0→E1.
- **`o_enc_rst_n`:** high from E0 to E8; low for at least one cycle between frames, which puts the encoder back at step 0.
- **`o_code`/`o_code_id`:** hold their values until the next `o_code_valid`.
- **`o_busy`:** 1 from E0 through E8 (or through the error edge).
- **`o_err`:** asserted on the edge of the first failing check only.

## Test plan
- **Reset, single requester:** reset, then `i_req`=0001 with word 3'b100.
  - Required: `o_gnt`=0001 one cycle later.
  - Required: 8 cycles after the grant, `o_code`=7'b1001011, `o_code_id`=0, one-cycle `o_code_valid`.
- **Code values:** word 3'b111 must give `o_code`=7'b1110010. Word 3'b000 must give 7'b0000000.
- **Round-robin fairness:** hold `i_req`=1111 continuously.
  - Required grant order: 0,1,2,3,0.
  - Required: grants exactly 9 cycles apart, and the `o_code_id` sequence matches the grant order.
- **Skip and wrap:** `last`=1, `i_req`=1001. Required: requester 3 is granted, then requester 0.
- **Protocol error:** an encoder stub asserts `i_enc_done` at E5.
  - Required: `o_err` pulses at E5, no `o_code_valid`, `o_enc_rst_n`=0, IDLE next cycle.
  - Required: a stub that holds done low at E8 also gives `o_err`.
- **Mid-frame reset:** assert `i_rst` at E4.
  - Required: all outputs 0, no valid or err pulse.
  - Required: the next request grants requester 0 first.
